// File: rtl/riscv_pkg.sv
// Shared register-file geometry and helpers for the writeback slice.
package riscv_pkg;

   localparam int unsigned XLEN_DFLT  = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;

   function automatic logic is_x0(input logic [REG_ADDR_W-1:0] rd);
      return rd == '0;
   endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters; drives busy, issue backpressure and the sticky error.
module wb_scoreboard
   import riscv_pkg::*;
#(
   parameter int unsigned CNT_W = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inc_valid,
   input  logic [REG_ADDR_W-1:0] inc_rd,
   output logic                  inc_ready,
   input  logic                  dec_valid,
   input  logic [REG_ADDR_W-1:0] dec_rd,
   output logic [NUM_REGS-1:0]   busy,
   output logic                  sb_err
);

   logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic                           err_q, err_d;
   logic                           inc_fire;

   assign inc_ready = is_x0(inc_rd) || (cnt_q[inc_rd] != '1);
   assign inc_fire  = inc_valid && inc_ready && !is_x0(inc_rd);

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      for (int r = 1; r < NUM_REGS; r++) begin
         // Same-cycle issue and retire on one register cancel out.
         if (inc_fire && (inc_rd == REG_ADDR_W'(r)) &&
             !(dec_valid && (dec_rd == REG_ADDR_W'(r)))) begin
            cnt_d[r] = cnt_q[r] + 1'b1;
         end else if (dec_valid && (dec_rd == REG_ADDR_W'(r)) &&
                      !(inc_fire && (inc_rd == REG_ADDR_W'(r)))) begin
            if (cnt_q[r] == '0) begin
               err_d = 1'b1;
            end else begin
               cnt_d[r] = cnt_q[r] - 1'b1;
            end
         end
      end
      cnt_d[0] = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   always_comb begin
      busy = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         busy[r] = (cnt_q[r] != '0);
      end
   end

   assign sb_err = err_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: arbitrates ALU and LSU results onto the single register-file write port.
module wb_arbiter
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN       = XLEN_DFLT,
   parameter int unsigned CNT_W      = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   output logic                  issue_ready,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   output logic                  alu_ready,
   input  logic                  lsu_valid,
   input  logic [REG_ADDR_W-1:0] lsu_rd,
   input  logic [XLEN-1:0]       lsu_data,
   output logic                  lsu_ready,
   output logic                  wen,
   output logic [REG_ADDR_W-1:0] wadd,
   output logic [XLEN-1:0]       wdata,
   output logic [NUM_REGS-1:0]   busy,
   output logic                  sb_err
);

   localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
   localparam logic [STARVE_W-1:0] StarveLim = STARVE_W'(STARVE_MAX);

   logic [STARVE_W-1:0]   starve_q, starve_d;
   logic                  wen_q, wen_d;
   logic [REG_ADDR_W-1:0] wadd_q, wadd_d;
   logic [XLEN-1:0]       wdata_q, wdata_d;
   logic                  force_alu, lsu_grant, alu_grant;

   // LSU wins unless the ALU has been passed over STARVE_MAX times in a row.
   always_comb begin
      force_alu = alu_valid && (starve_q == StarveLim);
      lsu_grant = lsu_valid && !force_alu;
      alu_grant = alu_valid && !lsu_grant;
   end

   assign lsu_ready = lsu_grant;
   assign alu_ready = alu_grant;

   always_comb begin
      starve_d = starve_q;
      if (!alu_valid || alu_grant) begin
         starve_d = '0;
      end else if (lsu_grant && (starve_q != StarveLim)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // x0 results are consumed but never reach the register file.
   always_comb begin
      wen_d   = 1'b0;
      wadd_d  = wadd_q;
      wdata_d = wdata_q;
      if (lsu_grant && !is_x0(lsu_rd)) begin
         wen_d   = 1'b1;
         wadd_d  = lsu_rd;
         wdata_d = lsu_data;
      end else if (alu_grant && !is_x0(alu_rd)) begin
         wen_d   = 1'b1;
         wadd_d  = alu_rd;
         wdata_d = alu_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q <= '0;
         wen_q    <= 1'b0;
         wadd_q   <= '0;
         wdata_q  <= '0;
      end else begin
         starve_q <= starve_d;
         wen_q    <= wen_d;
         wadd_q   <= wadd_d;
         wdata_q  <= wdata_d;
      end
   end

   assign wen   = wen_q;
   assign wadd  = wadd_q;
   assign wdata = wdata_q;

   wb_scoreboard #(
      .CNT_W (CNT_W)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .inc_valid (issue_valid),
      .inc_rd    (issue_rd),
      .inc_ready (issue_ready),
      .dec_valid (wen_q),
      .dec_rd    (wadd_q),
      .busy      (busy),
      .sb_err    (sb_err)
   );

endmodule
